vga_mem_arbiter: RTL and testbench

VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

---
 rtl/vga_pkg.sv | 24 ++
 rtl/vga_pix_addr.sv | 32 +++
 rtl/vga_mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_vga_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared framebuffer geometry and the CPU-side FSM state
//               encoding for the VGA framebuffer memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  localparam int FB_W        = 160;   // framebuffer width in pixels
  localparam int FB_H        = 120;   // framebuffer height in pixels
  localparam int SCALE_SHIFT = 2;     // 640x480 screen -> 160x120 framebuffer
  localparam int ADDR_W      = 15;    // framebuffer address width
  localparam int FB_DEPTH    = FB_W * FB_H;

  // CPU access sequencer states
  typedef enum logic [1:0] {
    CPU_IDLE   = 2'd0,
    CPU_RD_CAP = 2'd1,
    CPU_ACK    = 2'd2
  } cpu_state_e;

endpackage : vga_pkg
`default_nettype wire

// File: rtl/vga_pix_addr.sv
`default_nettype none
// ============================================================================
// Module      : vga_pix_addr
// Description : Combinational map from screen coordinates to a linear
//               framebuffer address: (v >> S) * FB_W + (h >> S).
// Ports       : h_count_i  - horizontal screen coordinate (10 bits)
//               v_count_i  - vertical screen coordinate (10 bits)
//               addr_o     - framebuffer address (ADDR_W bits)
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pix_addr #(
  parameter int FB_W        = 160,
  parameter int SCALE_SHIFT = 2,
  parameter int ADDR_W      = 15
) (
  input  logic [9:0]        h_count_i,
  input  logic [9:0]        v_count_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [9:0] w_fb_x;
  logic [9:0] w_fb_y;

  assign w_fb_x = h_count_i >> SCALE_SHIFT;
  assign w_fb_y = v_count_i >> SCALE_SHIFT;

  // Arithmetic is done at 32 bits and truncated; for in-range coordinates the
  // result always fits in ADDR_W.
  assign addr_o = ADDR_W'(32'(w_fb_y) * 32'(FB_W) + 32'(w_fb_x));

endmodule : vga_pix_addr
`default_nettype wire

// File: rtl/vga_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vga_mem_arbiter
// Description : Shares one single-port synchronous framebuffer RAM between
//               the VGA pixel fetch (absolute priority on countEn slots) and
//               a CPU request/ack port. Produces the RRRGGGBB pixel stream.
// Ports       : clk, rst (async, active-low)
//               countEn, bright, hCount, vCount   - VGA timing inputs
//               cpu_req/we/addr/wdata, cpu_ack/rdata - CPU handshake
//               mem_addr/we/wdata, mem_rdata        - RAM port
//               pix_data                            - pixel to colour expander
// Revision    : 1.0 - initial release
// ============================================================================
module vga_mem_arbiter #(
  parameter int FB_W        = vga_pkg::FB_W,
  parameter int FB_H        = vga_pkg::FB_H,
  parameter int SCALE_SHIFT = vga_pkg::SCALE_SHIFT,
  parameter int ADDR_W      = vga_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              countEn,
  input  logic              bright,
  input  logic [9:0]        hCount,
  input  logic [9:0]        vCount,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        pix_data
);

  import vga_pkg::*;

  localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(FB_W * FB_H);

  cpu_state_e        state_q;
  logic [ADDR_W-1:0] last_addr_q;
  logic              inrange_q;
  logic [7:0]        rdata_q;
  logic              ack_q;
  logic              slot_q;
  logic              vis_q;
  logic [7:0]        pix_q;

  logic [ADDR_W-1:0] w_vga_addr;
  logic              w_in_range;
  logic              w_issue;

  vga_pix_addr #(
    .FB_W        (FB_W),
    .SCALE_SHIFT (SCALE_SHIFT),
    .ADDR_W      (ADDR_W)
  ) u_pix_addr (
    .h_count_i (hCount),
    .v_count_i (vCount),
    .addr_o    (w_vga_addr)
  );

  assign w_in_range = ({1'b0, cpu_addr} < c_depth);

  // The CPU gets the port only in IDLE on a non-slot cycle. rst is folded in
  // so the RAM sees no write while reset is asserted, even before the
  // asynchronous clear has propagated through the state register.
  assign w_issue = rst && (state_q == CPU_IDLE) && cpu_req && !countEn;

  always_comb begin
    mem_addr  = last_addr_q;
    mem_we    = 1'b0;
    mem_wdata = cpu_wdata;
    if (countEn) begin
      mem_addr = w_vga_addr;
    end else if (w_issue) begin
      mem_addr = cpu_addr;
      mem_we   = cpu_we && w_in_range;
    end
  end

  // Pixel pipeline: slot edge captures visibility, next edge captures RAM data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q <= 1'b0;
      vis_q  <= 1'b0;
      pix_q  <= 8'h00;
    end else begin
      slot_q <= countEn;
      if (countEn) begin
        vis_q <= bright;
      end
      if (slot_q) begin
        pix_q <= vis_q ? mem_rdata : 8'h00;
      end
    end
  end

  // CPU access sequencer with registered ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= CPU_IDLE;
      last_addr_q <= '0;
      inrange_q   <= 1'b0;
      rdata_q     <= 8'h00;
      ack_q       <= 1'b0;
    end else begin
      case (state_q)
        CPU_IDLE: begin
          ack_q <= 1'b0;
          if (cpu_req && !countEn) begin
            last_addr_q <= cpu_addr;
            inrange_q   <= w_in_range;
            if (cpu_we) begin
              state_q <= CPU_ACK;
              ack_q   <= 1'b1;
            end else begin
              state_q <= CPU_RD_CAP;
            end
          end
        end
        CPU_RD_CAP: begin
          // RAM data for the address issued last cycle is valid now.
          rdata_q <= inrange_q ? mem_rdata : 8'h00;
          state_q <= CPU_ACK;
          ack_q   <= 1'b1;
        end
        CPU_ACK: begin
          ack_q   <= 1'b0;
          state_q <= CPU_IDLE;
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= CPU_IDLE;
        end
      endcase
    end
  end

  assign cpu_ack   = ack_q;
  assign cpu_rdata = rdata_q;
  assign pix_data  = pix_q;

endmodule : vga_mem_arbiter
`default_nettype wire

// File: tb/tb_vga_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_mem_arbiter
// Description : Self-checking bench for vga_mem_arbiter. A behavioural RAM,
//               a framebuffer reference model and a scoreboard queue of
//               expected CPU responses; a monitor checks acks and pixels.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_mem_arbiter;

  localparam int DEPTH = 160 * 120;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        countEn = 1'b0;
  logic        bright = 1'b0;
  logic [9:0]  hCount = '0;
  logic [9:0]  vCount = '0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [14:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic [7:0]  pix_data;

  always #5 clk = ~clk;

  vga_mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .countEn   (countEn),
    .bright    (bright),
    .hCount    (hCount),
    .vCount    (vCount),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .pix_data  (pix_data)
  );

  // Initial RAM contents as a function of address
  function automatic logic [7:0] pat(input int a);
    if (a == 162)   return 8'hE3;
    if (a == 19199) return 8'h77;
    return 8'(a * 37 + 5);
  endfunction

  // Synchronous single-port RAM model (read-old-data)
  logic [7:0] ram_w [int];
  always @(posedge clk) begin
    automatic int a = int'(mem_addr);
    mem_rdata <= ram_w.exists(a) ? ram_w[a] : pat(a);
    if (mem_we) ram_w[a] = mem_wdata;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int vga_addr(input int h, input int v);
    return (v / 4) * 160 + (h / 4);
  endfunction

  // Reference framebuffer and CPU response scoreboard
  logic [7:0] ref_fb [DEPTH];
  typedef struct {
    logic       we;
    logic [7:0] rd;
  } exp_t;
  exp_t sbq[$];

  bit          ce_prev = 1'b0;
  logic [14:0] last_addr = '0;
  bit          have_last = 1'b0;
  bit          expect_issue = 1'b0;

  // mode 0: no slot, 1: random slot, 2: forced slot at (h,v,br)
  task automatic cyc_begin(input int mode, input int h, input int v, input bit br);
    @(negedge clk);
    if (mode == 2) begin
      countEn = 1'b1;
      hCount  = 10'(h);
      vCount  = 10'(v);
      bright  = br;
    end else begin
      countEn = (mode == 1) && !ce_prev && ($urandom_range(0, 2) == 0);
      hCount  = 10'($urandom_range(0, 639));
      vCount  = 10'($urandom_range(40, 399));
      bright  = 1'($urandom_range(0, 1));
    end
    ce_prev = countEn;
  endtask

  task automatic cyc_check();
    #1;
    if (rst) begin
      if (countEn) begin
        chk("slot_addr", 32'(mem_addr), 32'(vga_addr(int'(hCount), int'(vCount))));
        chk("slot_we", 32'(mem_we), 32'd0);
      end else if (!expect_issue) begin
        chk("idle_we", 32'(mem_we), 32'd0);
        if (have_last) chk("idle_addr", 32'(mem_addr), 32'(last_addr));
      end
    end
  endtask

  // smode 0: no slots, 1: random slots, 2: slot on first cycle then none
  task automatic cpu_op(input bit we, input int addr, input logic [7:0] wd, input int smode);
    exp_t e;
    int   g;
    int   lat;
    bit   done;
    e.we = we;
    e.rd = (!we && addr < DEPTH) ? ref_fb[addr] : 8'h00;
    sbq.push_back(e);
    if (we && addr < DEPTH) ref_fb[addr] = wd;
    g    = -1;
    lat  = we ? 1 : 2;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      if (i == 0 && smode == 2) cyc_begin(2, 8, 4, 1'b1);
      else                      cyc_begin((smode == 1) ? 1 : 0, 0, 0, 1'b0);
      if (i == 0) begin
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = 15'(addr);
        cpu_wdata = wd;
      end
      expect_issue = (g < 0) && !countEn;
      cyc_check();
      if (expect_issue) begin
        g = i;
        chk("grant_addr", 32'(mem_addr), 32'(addr));
        chk("grant_we", 32'(mem_we), 32'(we && addr < DEPTH));
        last_addr = 15'(addr);
        have_last = 1'b1;
      end
      if (g >= 0 && i == g + lat) begin
        chk("ack_latency", 32'(cpu_ack), 32'd1);
        cpu_req = 1'b0;
        done    = 1'b1;
      end else begin
        chk("no_early_ack", 32'(cpu_ack), 32'd0);
      end
      expect_issue = 1'b0;
    end
    if (!done) begin
      chk("ack_timeout", 32'(done), 32'd1);
      cpu_req = 1'b0;
    end
  endtask

  // Monitor: pixels two edges after a slot, pixel hold otherwise, CPU acks.
  bit         pend = 1'b0;
  bit         mon_had;
  logic [7:0] pend_exp = '0;
  logic [7:0] mon_exp;
  logic [7:0] hold_pix = '0;
  always begin
    @(posedge clk);
    mon_had = pend;
    mon_exp = pend_exp;
    if (rst && countEn) begin
      pend     = 1'b1;
      pend_exp = bright ? ref_fb[vga_addr(int'(hCount), int'(vCount))] : 8'h00;
    end else begin
      pend = 1'b0;
    end
    #2;
    if (!rst) begin
      hold_pix = 8'h00;
      pend     = 1'b0;
    end else begin
      if (mon_had) hold_pix = mon_exp;
      chk("pix_data", 32'(pix_data), 32'(hold_pix));
      if (cpu_ack) begin
        chk("ack_expected", 32'(sbq.size() > 0), 32'd1);
        if (sbq.size() > 0) begin
          exp_t e;
          e = sbq.pop_front();
          if (!e.we) chk("cpu_rdata", 32'(cpu_rdata), 32'(e.rd));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_fb[i] = pat(i);

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ack", 32'(cpu_ack), 32'd0);
    chk("rst_pix", 32'(pix_data), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_rdata", 32'(cpu_rdata), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) begin cyc_begin(0, 0, 0, 1'b0); cyc_check(); end

    // Visible slot at (8,4) -> address 162, pixel 0xE3 two edges later
    cyc_begin(2, 8, 4, 1'b1); cyc_check();
    chk("slot_162", 32'(mem_addr), 32'd162);
    cyc_begin(0, 0, 0, 1'b0); cyc_check();
    cyc_begin(0, 0, 0, 1'b0); cyc_check();
    chk("pix_E3", 32'(pix_data), 32'hE3);

    // Bottom-right corner, not visible -> address 19199, pixel 0x00
    cyc_begin(2, 639, 479, 1'b0); cyc_check();
    chk("slot_19199", 32'(mem_addr), 32'd19199);
    cyc_begin(0, 0, 0, 1'b0); cyc_check();
    cyc_begin(0, 0, 0, 1'b0); cyc_check();
    chk("pix_dark", 32'(pix_data), 32'h00);

    // Write then read back
    cpu_op(1'b1, 100, 8'h5A, 0);
    cpu_op(1'b0, 100, 8'h00, 0);

    // Out-of-range write suppressed, out-of-range read returns zero
    cpu_op(1'b1, 19200, 8'hAB, 0);
    cpu_op(1'b0, 30000, 8'h00, 0);

    // Request raised in a slot: stalled one cycle, pixel fetch undisturbed
    cyc_begin(0, 0, 0, 1'b0); cyc_check();
    cpu_op(1'b1, 200, 8'h11, 2);
    repeat (2) begin cyc_begin(0, 0, 0, 1'b0); cyc_check(); end
    chk("pix_after_stall", 32'(pix_data), 32'hE3);
    cpu_op(1'b0, 100, 8'h00, 0);

    // Reset during RD_CAP
    cyc_begin(0, 0, 0, 1'b0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'd100;
    expect_issue = 1'b1;
    cyc_check();
    expect_issue = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ack", 32'(cpu_ack), 32'd0);
    chk("abort_pix", 32'(pix_data), 32'd0);
    chk("abort_we", 32'(mem_we), 32'd0);
    chk("abort_rdata", 32'(cpu_rdata), 32'd0);
    cpu_req = 1'b0;
    repeat (3) begin
      cyc_begin(0, 0, 0, 1'b0);
      #1;
      chk("rst_hold_ack", 32'(cpu_ack), 32'd0);
      chk("rst_hold_we", 32'(mem_we), 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    have_last = 1'b0;
    repeat (4) begin cyc_begin(1, 0, 0, 1'b0); cyc_check(); end
    cpu_op(1'b0, 100, 8'h00, 1);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      int  k;
      bit  we;
      int  a;
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) begin cyc_begin(1, 0, 0, 1'b0); cyc_check(); end
      we = 1'($urandom_range(0, 1));
      if (we) a = ($urandom_range(0, 4) == 0) ? $urandom_range(19200, 32767)
                                              : $urandom_range(16000, 19199);
      else    a = $urandom_range(0, 32767);
      cpu_op(we, a, 8'($urandom_range(0, 255)), 1);
    end

    repeat (4) begin cyc_begin(1, 0, 0, 1'b0); cyc_check(); end
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_vga_mem_arbiter
`default_nettype wire
